tl_ul_ram: RTL

TL_UL_RAM -- requirements
Module: tl_ul_ram

---
 rtl/tl_ul_ram_if.sv | 35 +++
 rtl/tl_ul_ram.sv | 94 +++++++++
 2 files changed

// File: rtl/tl_ul_ram_if.sv
// tl_ul_ram_if: TileLink-UL A/D channel bundle between a master and the RAM slave
interface tl_ul_ram_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SOURCE_W = 1
);
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [2:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [ADDR_W-1:0]   a_address;
    logic [DATA_W/8-1:0] a_mask;
    logic [DATA_W-1:0]   a_data;
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [2:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_sink;
    logic [DATA_W-1:0]   d_data;
    logic                d_error;
    logic                d_valid;
    logic                d_ready;

    modport master (
        output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid, d_ready,
        input  a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error, d_valid
    );

    modport slave (
        input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_valid, d_ready,
        output a_ready, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error, d_valid
    );
endinterface

// File: rtl/tl_ul_ram.sv
// tl_ul_ram: TileLink-UL single-beat RAM slave with an in-order response queue
module tl_ul_ram #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int SOURCE_W   = 1,
    parameter int RESP_DEPTH = 2
) (
    input logic        clock,
    input logic        rst_n,
    tl_ul_ram_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          size;
        logic [SOURCE_W-1:0] source;
        logic                error;
        logic [DATA_W-1:0]   data;
    } resp_t;

    logic [DATA_W-1:0] mem [DEPTH];
    resp_t             q [RESP_DEPTH];
    resp_t             head, push_resp;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  idx;
    logic [ADDR_W-1:0] word_addr, align_mask;
    logic              legal, is_put, is_get, is_hint, push, pop;
    logic              unused_param;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return p == PTR_W'(RESP_DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx          = bus.a_address[OFF+IDX_W-1:OFF];
    assign word_addr    = bus.a_address >> OFF;
    assign align_mask   = (ADDR_W'(1) << bus.a_size) - ADDR_W'(1);
    assign legal        = bus.a_size <= 3'(OFF) && (bus.a_address & align_mask) == '0
                          && word_addr < ADDR_W'(DEPTH);
    assign is_put       = legal && (bus.a_opcode == 3'd0 || bus.a_opcode == 3'd1);
    assign is_get       = bus.a_opcode == 3'd4;
    assign is_hint      = legal && bus.a_opcode == 3'd5;
    assign unused_param = ^bus.a_param;

    // a_ready depends only on registered occupancy, never on d_ready
    assign bus.a_ready = count != CNT_W'(RESP_DEPTH);
    assign push        = rst_n && bus.a_valid && bus.a_ready;
    assign pop         = bus.d_valid && bus.d_ready;

    always_comb begin
        push_resp.opcode = is_get ? 3'd1 : is_hint ? 3'd2 : 3'd0;
        push_resp.size   = bus.a_size;
        push_resp.source = bus.a_source;
        push_resp.error  = !(is_put || is_hint || (is_get && legal));
        push_resp.data   = is_get && legal ? mem[idx] : '0;
    end

    always_ff @(posedge clock)
        if (push && is_put)
            for (int i = 0; i < BYTES; i++)
                if (bus.a_mask[i]) mem[idx][8*i +: 8] <= bus.a_data[8*i +: 8];

    always_ff @(posedge clock)
        if (push) q[wr_ptr] <= push_resp;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wrap_inc(wr_ptr) : wr_ptr;
            rd_ptr <= pop ? wrap_inc(rd_ptr) : rd_ptr;
            count  <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // payload is forced to zero while the queue is empty
    assign head         = q[rd_ptr];
    assign bus.d_valid  = count != '0;
    assign bus.d_opcode = bus.d_valid ? head.opcode : '0;
    assign bus.d_size   = bus.d_valid ? head.size : '0;
    assign bus.d_source = bus.d_valid ? head.source : '0;
    assign bus.d_error  = bus.d_valid ? head.error : 1'b0;
    assign bus.d_data   = bus.d_valid ? head.data : '0;
    assign bus.d_param  = '0;
    assign bus.d_sink   = 1'b0;
endmodule
